// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: state codes, opcode and
// funct constants, datapath select encodings and the decoded instruction class.
// Pure definitions; no logic, no latency, no flow control.
package mc_ctrl_pkg;

  // Control FSM state codes (3-bit state register).
  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EXE  = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5
  } state_e;

  // Primary opcodes, instruction[31:26].
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes, instruction[5:0].
  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_JR   = 6'h08;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;

  // Next-PC source select.
  typedef enum logic [1:0] {
    NPC_PLUS4  = 2'd0,
    NPC_BRANCH = 2'd1,
    NPC_JUMP   = 2'd2,
    NPC_JR     = 2'd3
  } npc_op_e;

  // ALU operation. ADD is zero so an idle/reset ALU select is an add.
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4,
    ALU_SLL = 4'd5,
    ALU_LUI = 4'd6
  } alu_op_e;

  // Register-file write-data source.
  typedef enum logic [1:0] {
    WD_ALU = 2'd0,
    WD_MEM = 2'd1,
    WD_PC  = 2'd2
  } wd_sel_e;

  // Register-file destination select.
  typedef enum logic [1:0] {
    GPR_RD  = 2'd0,
    GPR_RT  = 2'd1,
    GPR_R31 = 2'd2
  } gpr_sel_e;

  // One-hot-ish instruction class produced by the decoder; exactly one bit
  // is set for any opcode/funct pair.
  typedef struct packed {
    logic r_alu;    // addu, subu, and, or, slt, sll
    logic i_alu;    // addiu, ori, lui
    logic lw;
    logic sw;
    logic beq;
    logic bne;
    logic j;
    logic jal;
    logic jr;
    logic illegal;
  } inst_class_t;

  // Instructions that finish with a register write-back of the ALU result.
  function automatic logic goes_to_wb(input inst_class_t c);
    return c.r_alu | c.i_alu;
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Instruction decoder: Op/Funct -> instruction class plus ALU/extension selects.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the inputs every cycle.
//
// Ports:
//   Op, Funct   in   instruction[31:26] and instruction[5:0]
//   cls         out  instruction class vector (exactly one bit set)
//   alu_op      out  ALU operation for EXE/MEM/WB
//   bsel        out  ALU B operand: 0 = register, 1 = immediate
//   extop       out  immediate extension: 0 = zero, 1 = sign
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0]  Op,
  input  logic [5:0]  Funct,
  output inst_class_t cls,
  output alu_op_e     alu_op,
  output logic        bsel,
  output logic        extop
);

  always_comb begin
    cls    = '0;
    alu_op = ALU_ADD;
    bsel   = 1'b0;
    extop  = 1'b0;

    case (Op)
      OP_RTYPE: begin
        cls.r_alu = 1'b1;
        case (Funct)
          FUNCT_ADDU: alu_op = ALU_ADD;
          FUNCT_SUBU: alu_op = ALU_SUB;
          FUNCT_AND:  alu_op = ALU_AND;
          FUNCT_OR:   alu_op = ALU_OR;
          FUNCT_SLT:  alu_op = ALU_SLT;
          FUNCT_SLL:  alu_op = ALU_SLL;
          FUNCT_JR: begin
            cls.r_alu = 1'b0;
            cls.jr    = 1'b1;
          end
          default: begin
            cls.r_alu   = 1'b0;
            cls.illegal = 1'b1;
          end
        endcase
      end
      OP_ADDIU: begin
        cls.i_alu = 1'b1;
        alu_op    = ALU_ADD;
        bsel      = 1'b1;
        extop     = 1'b1;
      end
      OP_ORI: begin
        // Logical immediate: upper half must be zero, not sign bits.
        cls.i_alu = 1'b1;
        alu_op    = ALU_OR;
        bsel      = 1'b1;
      end
      OP_LUI: begin
        // The ALU shifts the immediate into the upper half, so the
        // extension mode does not matter; keep it at zero.
        cls.i_alu = 1'b1;
        alu_op    = ALU_LUI;
        bsel      = 1'b1;
      end
      OP_LW: begin
        cls.lw = 1'b1;
        alu_op = ALU_ADD;
        bsel   = 1'b1;
        extop  = 1'b1;
      end
      OP_SW: begin
        cls.sw = 1'b1;
        alu_op = ALU_ADD;
        bsel   = 1'b1;
        extop  = 1'b1;
      end
      OP_BEQ: begin
        // Compare by subtraction; the sign-extended offset feeds the
        // branch-target adder, not the ALU B input.
        cls.beq = 1'b1;
        alu_op  = ALU_SUB;
        extop   = 1'b1;
      end
      OP_BNE: begin
        cls.bne = 1'b1;
        alu_op  = ALU_SUB;
        extop   = 1'b1;
      end
      OP_J:    cls.j   = 1'b1;
      OP_JAL:  cls.jal = 1'b1;
      default: cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle CPU control FSM: sequences IF/ID/EXE/MEM/WB and drives datapath enables/selects.
// Latency: outputs are combinational from the state register and decoded Op/Funct.
// Backpressure: with MEM_WAIT_EN defined, IF and MEM stall until mem_ready; otherwise none.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   Op, Funct       instruction fields from the IR
//   Zero            ALU zero flag, only looked at in EXE of a branch
//   mem_ready       memory handshake (only when MEM_WAIT_EN is defined)
//   PCWr, IRWr, RFWr, DMWr   datapath write enables
//   NPCOp, ALUOp, WDSel, GPRSel, EXTOp, BSel   datapath selects
//   Illegal         one-cycle pulse in ID for an undecodable instruction
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
`ifdef MEM_WAIT_EN
  input  logic       mem_ready,
`endif
  output logic       PCWr,
  output logic       IRWr,
  output logic       RFWr,
  output logic       DMWr,
  output logic [1:0] NPCOp,
  output logic [3:0] ALUOp,
  output logic [1:0] WDSel,
  output logic [1:0] GPRSel,
  output logic       EXTOp,
  output logic       BSel,
  output logic       Illegal
);

  state_e      state_q, state_d;
  inst_class_t cls;
  alu_op_e     dec_alu_op;
  logic        dec_bsel;
  logic        dec_extop;
  logic        mem_rdy;

  // Raw per-state controls, before the reset override.
  logic        pc_wr, ir_wr, rf_wr, dm_wr, ill;
  npc_op_e     npc_op;
  alu_op_e     alu_op;
  wd_sel_e     wd_sel;
  gpr_sel_e    gpr_sel;
  logic        extop, bsel;

`ifdef MEM_WAIT_EN
  assign mem_rdy = mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  mc_decode u_decode (
    .Op     (Op),
    .Funct  (Funct),
    .cls    (cls),
    .alu_op (dec_alu_op),
    .bsel   (dec_bsel),
    .extop  (dec_extop)
  );

  // State register. Reset parks in S_INIT so the PC gets its own load-zero
  // cycle before the first fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT: state_d = S_IF;
      S_IF:   state_d = mem_rdy ? S_ID : S_IF;
      S_ID: begin
        if (cls.j | cls.jal | cls.jr | cls.illegal) begin
          state_d = S_IF;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        if (cls.lw | cls.sw) begin
          state_d = S_MEM;
        end else if (goes_to_wb(cls)) begin
          state_d = S_WB;
        end else begin
          state_d = S_IF;
        end
      end
      S_MEM: begin
        if (!mem_rdy) begin
          state_d = S_MEM;
        end else if (cls.sw) begin
          state_d = S_IF;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB:    state_d = S_IF;
      default: state_d = S_INIT;
    endcase
  end

  // Per-state output logic.
  always_comb begin
    pc_wr   = 1'b0;
    ir_wr   = 1'b0;
    rf_wr   = 1'b0;
    dm_wr   = 1'b0;
    ill     = 1'b0;
    npc_op  = NPC_PLUS4;
    alu_op  = ALU_ADD;
    wd_sel  = WD_ALU;
    gpr_sel = GPR_RD;
    extop   = 1'b0;
    bsel    = 1'b0;

    // Operand selects stay stable from EXE through WB so the datapath's
    // address/result paths do not glitch between phases.
    if (state_q inside {S_EXE, S_MEM, S_WB}) begin
      alu_op = dec_alu_op;
      bsel   = dec_bsel;
      extop  = dec_extop;
    end

    case (state_q)
      S_IF: begin
        ir_wr  = mem_rdy;
        pc_wr  = mem_rdy;
        npc_op = NPC_PLUS4;
      end
      S_ID: begin
        if (cls.j) begin
          pc_wr  = 1'b1;
          npc_op = NPC_JUMP;
        end else if (cls.jal) begin
          pc_wr   = 1'b1;
          npc_op  = NPC_JUMP;
          rf_wr   = 1'b1;
          wd_sel  = WD_PC;
          gpr_sel = GPR_R31;
        end else if (cls.jr) begin
          pc_wr  = 1'b1;
          npc_op = NPC_JR;
        end else if (cls.illegal) begin
          ill = 1'b1;
        end
      end
      S_EXE: begin
        if (cls.beq | cls.bne) begin
          npc_op = NPC_BRANCH;
          pc_wr  = cls.beq ? Zero : !Zero;
        end
      end
      S_MEM: begin
        // Held high for the whole wait so the store lands whenever memory
        // accepts it.
        dm_wr = cls.sw;
      end
      S_WB: begin
        rf_wr   = 1'b1;
        wd_sel  = cls.lw ? WD_MEM : WD_ALU;
        gpr_sel = cls.r_alu ? GPR_RD : GPR_RT;
      end
      default: ;
    endcase
  end

  // Reset wins immediately, even mid-instruction: no enable may fire in the
  // cycle reset is seen, and selects fall back to their zero encodings.
  assign PCWr    = pc_wr & ~rst;
  assign IRWr    = ir_wr & ~rst;
  assign RFWr    = rf_wr & ~rst;
  assign DMWr    = dm_wr & ~rst;
  assign Illegal = ill   & ~rst;
  assign NPCOp   = rst ? 2'b00 : npc_op;
  assign ALUOp   = rst ? 4'b0000 : alu_op;
  assign WDSel   = rst ? 2'b00 : wd_sel;
  assign GPRSel  = rst ? 2'b00 : gpr_sel;
  assign EXTOp   = extop & ~rst;
  assign BSel    = bsel  & ~rst;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl.
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
// Output bundle: {PCWr,IRWr,RFWr,DMWr,Illegal,NPCOp[2],ALUOp[4],WDSel[2],GPRSel[2],EXTOp,BSel}.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] Op = 6'h00;
  logic [5:0] Funct = 6'h00;
  logic       Zero = 1'b0;
`ifdef MEM_WAIT_EN
  logic       mem_ready = 1'b1;
`endif
  logic       PCWr, IRWr, RFWr, DMWr, EXTOp, BSel, Illegal;
  logic [1:0] NPCOp, WDSel, GPRSel;
  logic [3:0] ALUOp;

  int n_vec = 0;
  int n_err = 0;

  logic [16:0] v_if;
  logic [16:0] v_zero;

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .Op        (Op),
    .Funct     (Funct),
    .Zero      (Zero),
`ifdef MEM_WAIT_EN
    .mem_ready (mem_ready),
`endif
    .PCWr      (PCWr),
    .IRWr      (IRWr),
    .RFWr      (RFWr),
    .DMWr      (DMWr),
    .NPCOp     (NPCOp),
    .ALUOp     (ALUOp),
    .WDSel     (WDSel),
    .GPRSel    (GPRSel),
    .EXTOp     (EXTOp),
    .BSel      (BSel),
    .Illegal   (Illegal)
  );

  wire [16:0] obs = {PCWr, IRWr, RFWr, DMWr, Illegal, NPCOp, ALUOp, WDSel, GPRSel, EXTOp, BSel};

  function automatic logic [16:0] mk(input logic p, input logic i, input logic r,
                                     input logic d, input logic il, input logic [1:0] npc,
                                     input logic [3:0] alu, input logic [1:0] wd,
                                     input logic [1:0] gpr, input logic ext, input logic b);
    return {p, i, r, d, il, npc, alu, wd, gpr, ext, b};
  endfunction

  // Held in reset for two cycles, then the single S_INIT cycle.
  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      n_vec++;
      if (obs !== v_zero) begin
        n_err++;
        $display("FAIL reset_hold cyc%0d got %h exp %h", k, obs, v_zero);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++;
    if (obs !== v_zero) begin
      n_err++;
      $display("FAIL reset_init got %h exp %h", obs, v_zero);
    end
    @(negedge clk);
  endtask

  // addu: IF, ID, EXE, WB. Zero held high to show it is ignored.
  task automatic test_addu();
    logic [16:0] e [4];
    Op = 6'h00; Funct = 6'h21; Zero = 1'b1;
    e = '{v_if, v_zero, v_zero, mk(0,0,1,0,0, 2'd0, 4'd0, 2'd0, 2'd0, 0,0)};
    for (int k = 0; k < 4; k++) begin
      #1;
      n_vec++;
      if (obs !== e[k]) begin
        n_err++;
        $display("FAIL addu cyc%0d got %h exp %h", k, obs, e[k]);
      end
      @(negedge clk);
    end
  endtask

  // ori: zero-extended immediate, OR, write-back to rt.
  task automatic test_ori();
    logic [16:0] e [4];
    Op = 6'h0D; Funct = 6'h2A; Zero = 1'b0;
    e = '{v_if, v_zero, mk(0,0,0,0,0, 2'd0, 4'd3, 2'd0, 2'd0, 0,1),
          mk(0,0,1,0,0, 2'd0, 4'd3, 2'd0, 2'd1, 0,1)};
    for (int k = 0; k < 4; k++) begin
      #1;
      n_vec++;
      if (obs !== e[k]) begin
        n_err++;
        $display("FAIL ori cyc%0d got %h exp %h", k, obs, e[k]);
      end
      @(negedge clk);
    end
  endtask

  // lw: IF, ID, EXE, MEM, WB with WDSel=MEM and GPRSel=RT.
  task automatic test_lw();
    logic [16:0] e [5];
    Op = 6'h23; Funct = 6'h00;
    e = '{v_if, v_zero, mk(0,0,0,0,0, 2'd0, 4'd0, 2'd0, 2'd0, 1,1),
          mk(0,0,0,0,0, 2'd0, 4'd0, 2'd0, 2'd0, 1,1),
          mk(0,0,1,0,0, 2'd0, 4'd0, 2'd1, 2'd1, 1,1)};
    for (int k = 0; k < 5; k++) begin
      #1;
      n_vec++;
      if (obs !== e[k]) begin
        n_err++;
        $display("FAIL lw cyc%0d got %h exp %h", k, obs, e[k]);
      end
      @(negedge clk);
    end
  endtask

  // sw: DMWr only in MEM, then straight back to IF.
  task automatic test_sw();
    logic [16:0] e [4];
    Op = 6'h2B; Funct = 6'h00;
    e = '{v_if, v_zero, mk(0,0,0,0,0, 2'd0, 4'd0, 2'd0, 2'd0, 1,1),
          mk(0,0,0,1,0, 2'd0, 4'd0, 2'd0, 2'd0, 1,1)};
    for (int k = 0; k < 4; k++) begin
      #1;
      n_vec++;
      if (obs !== e[k]) begin
        n_err++;
        $display("FAIL sw cyc%0d got %h exp %h", k, obs, e[k]);
      end
      @(negedge clk);
    end
  endtask

  // beq/bne with both Zero values; PCWr in EXE follows the branch sense.
  task automatic test_branch();
    logic [5:0] ops [4];
    logic       zs  [4];
    logic       pcw [4];
    logic [16:0] e;
    ops = '{6'h04, 6'h04, 6'h05, 6'h05};
    zs  = '{1'b1, 1'b0, 1'b1, 1'b0};
    pcw = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int t = 0; t < 4; t++) begin
      Op = ops[t]; Funct = 6'h00; Zero = zs[t];
      for (int k = 0; k < 3; k++) begin
        e = (k == 0) ? v_if : (k == 1) ? v_zero
            : mk(pcw[t],0,0,0,0, 2'd1, 4'd1, 2'd0, 2'd0, 1,0);
        #1;
        n_vec++;
        if (obs !== e) begin
          n_err++;
          $display("FAIL branch op%h z%0d cyc%0d got %h exp %h", ops[t], zs[t], k, obs, e);
        end
        @(negedge clk);
      end
    end
    Zero = 1'b0;
  endtask

  // Two-cycle instructions: j, jal, jr, illegal opcode, illegal funct.
  task automatic test_jump_illegal();
    logic [5:0]  ops [5];
    logic [5:0]  fns [5];
    logic [16:0] ids [5];
    logic [16:0] e;
    ops = '{6'h02, 6'h03, 6'h00, 6'h3F, 6'h00};
    fns = '{6'h00, 6'h00, 6'h08, 6'h00, 6'h3F};
    ids[0] = mk(1,0,0,0,0, 2'd2, 4'd0, 2'd0, 2'd0, 0,0);
    ids[1] = mk(1,0,1,0,0, 2'd2, 4'd0, 2'd2, 2'd2, 0,0);
    ids[2] = mk(1,0,0,0,0, 2'd3, 4'd0, 2'd0, 2'd0, 0,0);
    ids[3] = mk(0,0,0,0,1, 2'd0, 4'd0, 2'd0, 2'd0, 0,0);
    ids[4] = mk(0,0,0,0,1, 2'd0, 4'd0, 2'd0, 2'd0, 0,0);
    for (int t = 0; t < 5; t++) begin
      Op = ops[t]; Funct = fns[t];
      for (int k = 0; k < 2; k++) begin
        e = (k == 0) ? v_if : ids[t];
        #1;
        n_vec++;
        if (obs !== e) begin
          n_err++;
          $display("FAIL jump_ill op%h fn%h cyc%0d got %h exp %h", ops[t], fns[t], k, obs, e);
        end
        @(negedge clk);
      end
    end
  endtask

`ifdef MEM_WAIT_EN
  // IF stalls three cycles without enables, then fetches on mem_ready.
  task automatic test_mem_wait();
    Op = 6'h00; Funct = 6'h21;
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_vec++;
      if (obs !== v_zero) begin
        n_err++;
        $display("FAIL if_wait cyc%0d got %h exp %h", k, obs, v_zero);
      end
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #1;
    n_vec++;
    if (obs !== v_if) begin
      n_err++;
      $display("FAIL if_ready got %h exp %h", obs, v_if);
    end
    @(negedge clk);
    #1;
    n_vec++;
    if (obs !== v_zero) begin
      n_err++;
      $display("FAIL if_advance got %h exp %h", obs, v_zero);
    end
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
  endtask
`endif

  // Reset asserted during MEM of sw: DMWr suppressed, then INIT, then IF.
  task automatic test_rst_mid_sw();
    logic [16:0] e [3];
    Op = 6'h2B; Funct = 6'h00;
    e = '{v_if, v_zero, mk(0,0,0,0,0, 2'd0, 4'd0, 2'd0, 2'd0, 1,1)};
    for (int k = 0; k < 3; k++) begin
      #1;
      n_vec++;
      if (obs !== e[k]) begin
        n_err++;
        $display("FAIL rst_sw cyc%0d got %h exp %h", k, obs, e[k]);
      end
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if (obs !== v_zero) begin
      n_err++;
      $display("FAIL rst_sw_mem got %h exp %h", obs, v_zero);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++;
    if (obs !== v_zero) begin
      n_err++;
      $display("FAIL rst_sw_init got %h exp %h", obs, v_zero);
    end
    @(negedge clk);
    #1;
    n_vec++;
    if (obs !== v_if) begin
      n_err++;
      $display("FAIL rst_sw_if got %h exp %h", obs, v_if);
    end
    @(negedge clk);
  endtask

  initial begin
    v_if   = mk(1,1,0,0,0, 2'd0, 4'd0, 2'd0, 2'd0, 0,0);
    v_zero = '0;
    test_reset();
    test_addu();
    test_ori();
    test_lw();
    test_sw();
    test_branch();
    test_jump_illegal();
`ifdef MEM_WAIT_EN
    test_mem_wait();
`endif
    test_rst_mid_sw();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout vectors %0d", n_vec);
    $fatal(1, "watchdog");
  end

endmodule
